// File: rtl/keypad_cmd_encoder.sv
// 4x4 keypad scanner/debouncer that turns presses into one-cycle command codes
// and a locally accumulated decimal operand for operation_control.
module keypad_cmd_encoder #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic [7:0] data_out,
  output logic [7:0] entry_val,
  output logic       next_is_b,
  output logic       digit_sat
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  localparam logic [1:0] S_SCAN  = 2'd0;
  localparam logic [1:0] S_DEB   = 2'd1;
  localparam logic [1:0] S_PRESS = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [1:0] K_DIGIT = 2'd0;
  localparam logic [1:0] K_OP    = 2'd1;
  localparam logic [1:0] K_ENT   = 2'd2;
  localparam logic [1:0] K_CLR   = 2'd3;

  localparam logic [3:0] IDLE = 4'b1111;

  logic [1:0]       state;
  logic [1:0]       row_idx;
  logic [1:0]       cap_c;
  logic [3:0]       cap_col;
  logic [3:0]       col_m, col_s;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] cnt;

  logic             one_low;
  logic [1:0]       low_idx;
  logic [3:0]       key_id;
  logic [1:0]       kind;
  logic [3:0]       digit;
  logic [3:0]       op;
  logic [11:0]      acc;

  // Only a single low column is a valid press; chords are treated as no key.
  always_comb begin
    one_low = 1'b1;
    low_idx = 2'd0;
    case (col_s)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  // Row index stays frozen outside SCAN, so it identifies the captured row.
  assign key_id = {row_idx, cap_c};

  always_comb begin
    kind  = K_DIGIT;
    digit = 4'd0;
    op    = IDLE;
    case (key_id)
      4'd0:  digit = 4'd1;
      4'd1:  digit = 4'd2;
      4'd2:  digit = 4'd3;
      4'd3:  begin kind = K_OP; op = 4'b0010; end
      4'd4:  digit = 4'd4;
      4'd5:  digit = 4'd5;
      4'd6:  digit = 4'd6;
      4'd7:  begin kind = K_OP; op = 4'b0011; end
      4'd8:  digit = 4'd7;
      4'd9:  digit = 4'd8;
      4'd10: digit = 4'd9;
      4'd11: begin kind = K_OP; op = 4'b0100; end
      4'd12: kind = K_CLR;
      4'd13: digit = 4'd0;
      4'd14: kind = K_ENT;
      default: begin kind = K_OP; op = 4'b0101; end
    endcase
  end

  // Worst case 255*10+9 = 2559 fits in 12 bits.
  assign acc = ({4'b0, entry_val} * 12'd10) + {8'b0, digit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_m     <= 4'b1111;
      col_s     <= 4'b1111;
      state     <= S_SCAN;
      row_idx   <= 2'd0;
      row       <= 4'b1110;
      div_cnt   <= '0;
      cnt       <= '0;
      cap_c     <= 2'd0;
      cap_col   <= 4'b1111;
      key_code  <= IDLE;
      data_out  <= 8'd0;
      entry_val <= 8'd0;
      next_is_b <= 1'b0;
      digit_sat <= 1'b0;
    end else begin
      col_m     <= col;
      col_s     <= col_m;
      key_code  <= IDLE;
      digit_sat <= 1'b0;
      case (state)
        S_SCAN: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (one_low) begin
              cap_col <= col_s;
              cap_c   <= low_idx;
              cnt     <= '0;
              state   <= S_DEB;
            end else begin
              row_idx <= row_idx + 2'd1;
              row     <= {row[2:0], row[3]};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_DEB: begin
          if (col_s == cap_col) begin
            if (cnt == CNT_LAST) state <= S_PRESS;
            else                 cnt   <= cnt + 1'b1;
          end else begin
            row_idx <= row_idx + 2'd1;
            row     <= {row[2:0], row[3]};
            state   <= S_SCAN;
          end
        end
        S_PRESS: begin
          case (kind)
            K_DIGIT: begin
              if (acc > 12'd255) begin
                entry_val <= 8'hFF;
                digit_sat <= 1'b1;
              end else begin
                entry_val <= acc[7:0];
              end
            end
            K_OP: key_code <= op;
            K_ENT: begin
              key_code  <= next_is_b ? 4'b0001 : 4'b0000;
              data_out  <= entry_val;
              entry_val <= 8'd0;
              next_is_b <= ~next_is_b;
            end
            default: begin
              key_code  <= 4'b1000;
              entry_val <= 8'd0;
              data_out  <= 8'd0;
              next_is_b <= 1'b0;
            end
          endcase
          cnt   <= '0;
          state <= S_HOLD;
        end
        default: begin
          // Release needs DEBOUNCE_CYC consecutive all-high samples; no auto-repeat.
          if (col_s == 4'b1111) begin
            if (cnt == CNT_LAST) begin
              row_idx <= row_idx + 2'd1;
              row     <= {row[2:0], row[3]};
              state   <= S_SCAN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_cmd_encoder.sv
// Directed bench for keypad_cmd_encoder: table of key presses with expected
// outputs, plus hand sequences for bounce, hold/re-press and mid-debounce reset.
module tb_keypad_cmd_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row, col, key_code;
  logic [7:0] data_out, entry_val;
  logic       next_is_b, digit_sat;

  keypad_cmd_encoder #(.SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code),
    .data_out(data_out), .entry_val(entry_val), .next_is_b(next_is_b),
    .digit_sat(digit_sat)
  );

  always #5 clk = ~clk;

  // Key model: a pressed key pulls its column low while its row is driven.
  logic [3:0] mask [4];
  always_comb begin
    col = 4'hF;
    for (int i = 0; i < 4; i++)
      if (!row[i]) col = col & ~mask[i];
  end

  int checks = 0;
  int errors = 0;
  int ev_cnt = 0;
  int sat_cnt = 0;
  logic [3:0] last_code = 4'hF;
  logic [3:0] prev_code = 4'hF;
  logic [7:0] data_at = 8'd0;

  always @(negedge clk) begin
    if (rst) begin
      prev_code = 4'hF;
    end else begin
      if (key_code != 4'hF) begin
        ev_cnt++;
        last_code = key_code;
        data_at = data_out;
        checks++;
        if (prev_code != 4'hF) begin
          errors++;
          $display("FAIL pulse_width: code %b follows non-idle %b, required idle", key_code, prev_code);
        end
      end
      if (digit_sat) sat_cnt++;
      prev_code = key_code;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic hold_key(input int r, input logic [3:0] m, input int hold, input int rel);
    mask[r] = m;
    repeat (hold) @(posedge clk);
    #1 mask[r] = 4'h0;
    repeat (rel) @(posedge clk);
    #1;
  endtask

  task automatic wait_row_enter(input logic [3:0] tgt, output bit ok);
    logic [3:0] p;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      p = row;
      @(posedge clk);
      #1;
      if (row == tgt && p != tgt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0] r;
    logic [3:0] m;
    int         ev;
    logic [3:0] code;
    logic [7:0] ent;
    logic [7:0] dat;
    logic       nb;
    int         sat;
  } vec_t;

  vec_t vec [18];

  initial begin
    bit ok;
    int ev0;
    for (int i = 0; i < 4; i++) mask[i] = 4'h0;

    //          row   cols     ev code   entry  data   nb  sat
    vec[0]  = '{2'd0, 4'b0001, 0, 4'hF, 8'd1,   8'd0,   0, 0}; // 1
    vec[1]  = '{2'd0, 4'b0010, 0, 4'hF, 8'd12,  8'd0,   0, 0}; // 2
    vec[2]  = '{2'd0, 4'b0100, 0, 4'hF, 8'd123, 8'd0,   0, 0}; // 3
    vec[3]  = '{2'd3, 4'b0100, 1, 4'h0, 8'd0,   8'd123, 1, 0}; // ENT -> A
    vec[4]  = '{2'd3, 4'b0100, 1, 4'h1, 8'd0,   8'd0,   0, 0}; // ENT -> B
    vec[5]  = '{2'd0, 4'b0100, 0, 4'hF, 8'd3,   8'd0,   0, 0}; // 3
    vec[6]  = '{2'd3, 4'b0010, 0, 4'hF, 8'd30,  8'd0,   0, 0}; // 0
    vec[7]  = '{2'd3, 4'b0010, 0, 4'hF, 8'd255, 8'd0,   0, 1}; // 0 saturates
    vec[8]  = '{2'd2, 4'b1000, 1, 4'h4, 8'd255, 8'd0,   0, 0}; // *
    vec[9]  = '{2'd1, 4'b1000, 1, 4'h3, 8'd255, 8'd0,   0, 0}; // -
    vec[10] = '{2'd3, 4'b1000, 1, 4'h5, 8'd255, 8'd0,   0, 0}; // /
    vec[11] = '{2'd1, 4'b0001, 0, 4'hF, 8'd255, 8'd0,   0, 1}; // 4 saturates
    vec[12] = '{2'd3, 4'b0100, 1, 4'h0, 8'd0,   8'd255, 1, 0}; // ENT
    vec[13] = '{2'd2, 4'b0001, 0, 4'hF, 8'd7,   8'd255, 1, 0}; // 7
    vec[14] = '{2'd0, 4'b0011, 0, 4'hF, 8'd7,   8'd255, 1, 0}; // chord ignored
    vec[15] = '{2'd3, 4'b0001, 1, 4'h8, 8'd0,   8'd0,   0, 0}; // CLR
    vec[16] = '{2'd1, 4'b0100, 0, 4'hF, 8'd6,   8'd0,   0, 0}; // 6
    vec[17] = '{2'd3, 4'b0100, 1, 4'h0, 8'd0,   8'd6,   1, 0}; // ENT

    repeat (3) @(posedge clk);
    #1;
    chk("rst_row", row, 4'b1110);
    chk("rst_key_code", key_code, 4'hF);
    chk("rst_data_out", data_out, 0);
    chk("rst_entry_val", entry_val, 0);
    chk("rst_next_is_b", next_is_b, 0);
    chk("rst_digit_sat", digit_sat, 0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      ev_cnt = 0; sat_cnt = 0; last_code = 4'hF; data_at = 8'd0;
      hold_key(vec[i].r, vec[i].m, 60, 40);
      chk($sformatf("v%0d_events", i), ev_cnt, vec[i].ev);
      chk($sformatf("v%0d_code", i), last_code, vec[i].code);
      if (vec[i].ev > 0) chk($sformatf("v%0d_data_at_pulse", i), data_at, vec[i].dat);
      chk($sformatf("v%0d_entry_val", i), entry_val, vec[i].ent);
      chk($sformatf("v%0d_data_out", i), data_out, vec[i].dat);
      chk($sformatf("v%0d_next_is_b", i), next_is_b, vec[i].nb);
      chk($sformatf("v%0d_sat", i), sat_cnt, vec[i].sat);
    end

    // Long hold of '+': one pulse, no repeat.
    ev_cnt = 0; last_code = 4'hF;
    hold_key(0, 4'b1000, 500, 40);
    chk("hold_events", ev_cnt, 1);
    chk("hold_code", last_code, 4'h2);

    // Short release inside HOLD does not count as a new press.
    ev_cnt = 0;
    hold_key(0, 4'b1000, 60, 3);
    hold_key(0, 4'b1000, 60, 40);
    chk("short_release_events", ev_cnt, 1);
    // Full release then re-press gives a second pulse.
    hold_key(0, 4'b1000, 60, 40);
    chk("re_press_events", ev_cnt, 2);

    // Bounce on key 8: low for 3 debounce cycles, then released.
    ev_cnt = 0; sat_cnt = 0;
    mask[2] = 4'b0010;
    wait_row_enter(4'b1011, ok);
    chk("bounce_row_enter", ok, 1);
    repeat (7) @(posedge clk);
    #1 mask[2] = 4'h0;
    chk("bounce_row_frozen", row, 4'b1011);
    wait_row_enter(4'b0111, ok);
    chk("bounce_row_advance", ok, 1);
    repeat (30) @(posedge clk);
    #1;
    chk("bounce_events", ev_cnt, 0);
    chk("bounce_entry_val", entry_val, 0);

    // Reset while key 5 is in debounce.
    mask[1] = 4'b0010;
    wait_row_enter(4'b1101, ok);
    chk("rstdeb_row_enter", ok, 1);
    repeat (6) @(posedge clk);
    ev0 = ev_cnt;
    #1 rst = 1'b1;
    #1;
    chk("rstdeb_row", row, 4'b1110);
    chk("rstdeb_key_code", key_code, 4'hF);
    chk("rstdeb_data_out", data_out, 0);
    chk("rstdeb_next_is_b", next_is_b, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rstdeb_row_after", row, 4'b1110);
    chk("rstdeb_events", ev_cnt, ev0);
    repeat (60) @(posedge clk);
    #1 mask[1] = 4'h0;
    repeat (40) @(posedge clk);
    #1;
    chk("rstdeb_redetect_entry", entry_val, 5);
    chk("rstdeb_redetect_events", ev_cnt, ev0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
